// File: rtl/seq_add_sub.sv
// seq_add_sub: chunk-serial add/subtract with valid/ready handshake and flags; define SEQ_ADD_SUB_SAT_EN for signed saturation
module seq_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             add_sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             v_o,
  output logic             z_o,
  output logic             n_o
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  if (WIDTH < 2 || WIDTH % CHUNK != 0) begin : g_bad_params
    $error("seq_add_sub: WIDTH must be >= 2 and a multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, r_q, r_d, s_q, s_d;
  logic [CW-1:0] cnt_q;
  logic [CHUNK:0] sum;
  logic c_q, cout_q, v_q, z_q, n_q, v_d, last;
  always_comb begin
    last = cnt_q == CW'(NCHUNK - 1);
    sum = {1'b0, a_q[cnt_q*CHUNK +: CHUNK]} + {1'b0, b_q[cnt_q*CHUNK +: CHUNK]} + (CHUNK+1)'(c_q);
    r_d = r_q;
    r_d[cnt_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    v_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (r_d[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SEQ_ADD_SUB_SAT_EN
    // on overflow the true result has the sign of A
    s_d = v_d ? {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}} : r_d;
`else
    s_d = r_d;
`endif
    state_d = state_q == IDLE ? (in_valid_i ? RUN : IDLE) :
              state_q == RUN  ? (last ? DONE : RUN) :
                                (out_ready_i ? IDLE : DONE);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      s_q <= '0;
      cout_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid_i) begin
        a_q <= a_i;
        b_q <= b_i ^ {WIDTH{add_sub_i}};
        c_q <= add_sub_i;
        cnt_q <= '0;
      end
      if (state_q == RUN) begin
        r_q <= r_d;
        c_q <= sum[CHUNK];
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          s_q <= s_d;
          cout_q <= sum[CHUNK];
          v_q <= v_d;
          z_q <= s_d == '0;
          n_q <= s_d[WIDTH-1];
        end
      end
    end
  end
  assign in_ready_o = state_q == IDLE;
  assign out_valid_o = state_q == DONE;
  assign s_o = s_q;
  assign cout_o = cout_q;
  assign v_o = v_q;
  assign z_o = z_q;
  assign n_o = n_q;
endmodule

// File: doc/seq_add_sub.md
Name: seq_add_sub

Overview:
- Parametrised multi-cycle adder/subtractor. Processes a WIDTH-bit operand pair CHUNK bits per clock, from least significant chunk upward, with a ripple carry held in a register between chunks.
- Successor to the fixed 8-bit combinational add/sub stage. Adds a valid/ready handshake on input and output, a status-flag set, and optional signed saturation.
- Sits between operand registers and the result bus in the datapath.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be ≥ 2.
- CHUNK, 4, bits processed per cycle. Must divide WIDTH exactly; elaboration fails otherwise.
- NCHUNK is derived, not overridable: NCHUNK = WIDTH/CHUNK, the number of RUN cycles.

Ports:
- Clk  in  1  Single clock; all state changes on its rising edge.
- Reset  in  1  Synchronous, active-high reset.
- InValid  in  1  Operands and AddSub are valid.
- InReady  out  1  Block can accept operands. High only in IDLE.
- AddSub  in  1  Operation select: 0 = add, 1 = subtract (A − B).
- A  in  WIDTH  Operand A.
- B  in  WIDTH  Operand B.
- OutValid  out  1  Result and flags are valid.
- OutReady  in  1  Consumer accepts the result.
- S  out  WIDTH  Result.
- Cout  out  1  Carry out of the MSB. When subtracting, 1 = no borrow (A ≥ B unsigned).
- V  out  1  Signed overflow.
- Z  out  1  Result is all zeros.
- N  out  1  Result MSB.

Behaviour:
- Arithmetic:
  - Result = A + (B XOR {WIDTH{AddSub}}) + AddSub, computed modulo 2^WIDTH.
  - Carry into chunk 0 = AddSub.
  - V = carry into MSB XOR carry out of MSB.
  - Z and N are computed on the final S, i.e. after saturation when saturation is enabled.
- FSM states: IDLE, RUN, DONE.
  - IDLE: InReady = 1. On InValid = 1, capture A, the inverted-or-plain B, and AddSub. Clear the chunk counter, set the carry register to AddSub, go to RUN.
  - RUN: each cycle, add the current CHUNK slice plus the carry register. Write the sum slice into the result register and update the carry register. Increment the counter. After the NCHUNK-th slice, latch Cout, V, Z and N, then go to DONE.
  - DONE: OutValid = 1, and S and flags are held stable. On OutReady = 1, go to IDLE.
- Latency and throughput:
  - Accept edge e0; slices are processed at edges e1..eNCHUNK.
  - OutValid is high from edge eNCHUNK onward, until the edge where OutReady = 1 is sampled.
  - Minimum spacing between accepts is NCHUNK + 2 cycles.
- InValid is ignored outside IDLE. Input values are sampled only on the accept edge, so later changes to A, B or AddSub have no effect.
- OutReady is ignored outside DONE. OutReady already high on DONE entry gives a 1-cycle OutValid pulse.
- S and flags are undefined-but-stable in IDLE and RUN; the bench must check them only while OutValid = 1. The implementation holds the last result in these states.
- Reset:
  - Reset = 1 at any edge forces IDLE and discards any in-flight operation, including one in RUN or DONE.
  - Registered outputs reset to 0: S, Cout, V, Z, N, OutValid.
  - InReady is a decode of IDLE, so it reads 1 in the cycle after reset.
- Counter width is $clog2(NCHUNK) with a minimum of 1. CHUNK = WIDTH is legal and means one RUN cycle.

Optional Feature:
- Macro: SEQ_ADD_SUB_SAT_EN.
- Defined: on V = 1, S clamps to signed saturation in the DONE latch stage. Clamp value is 0x7FF…F if the true result is positive (operand A MSB = 0), else 0x800…0. V still reports 1. Cout reports the unsaturated carry.
- Not defined: S wraps modulo 2^WIDTH. No extra logic.

Test Plan (WIDTH = 16, CHUNK = 4 unless noted):
- Add 0x1234 + 0x4321 → S = 0x5555, Cout = 0, V = 0, Z = 0, N = 0. OutValid rises exactly 4 edges after the accept edge.
- Subtract 0x0005 − 0x0007 → S = 0xFFFE, Cout = 0, V = 0, N = 1. Subtract 0x1234 − 0x1234 → S = 0x0000, Z = 1, Cout = 1.
- Add 0x7FFF + 0x0001 → V = 1, N = 1, S = 0x8000; with SEQ_ADD_SUB_SAT_EN, S = 0x7FFF and N = 0. Subtract 0x8000 − 0x0001 → V = 1, Cout = 1, S = 0x7FFF; with the macro, S = 0x8000.
- Backpressure: hold OutReady = 0 for 5 cycles in DONE → S and flags stable, InReady = 0, a new InValid pulse is ignored. OutReady = 1 → IDLE on the next edge and InReady = 1.
- Reset asserted in the 2nd RUN cycle → next cycle IDLE, OutValid = 0, all registered outputs 0. A fresh 0x0001 + 0x0001 then completes with S = 0x0002.
- WIDTH = 8, CHUNK = 8, add 0xFF + 0x01 → 1-cycle RUN, S = 0x00, Cout = 1, Z = 1, V = 0.
